// File: rtl/clk_rst_seq_pkg.sv
// Shared types and limits for the clock-enable / reset sequencer.
package clk_rst_seq_pkg;

  localparam int MAX_NUM_CH = 8;
  localparam int IDX_W      = $clog2(MAX_NUM_CH);

  typedef enum logic [1:0] {
    S_ASSERT,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } seq_state_e;

endpackage

// File: rtl/clk_ce_div.sv
// Programmable divider: registered one-cycle clock enable every i_div+1 cycles
// plus a square-wave phase that toggles on each enable.
module clk_ce_div #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_ce,
  output logic             o_phi
);

  logic [DIV_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      o_ce  <= 1'b0;
      o_phi <= 1'b0;
    end else if (!i_en) begin
      cnt   <= '0;
      o_ce  <= 1'b0;
      o_phi <= 1'b0;
    end else begin
      o_phi <= o_phi ^ o_ce;
      // >= rather than == so a divisor lowered below the count wraps at once
      if (cnt >= i_div) begin
        cnt  <= '0;
        o_ce <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        o_ce <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// Per-channel clock enables plus a debounced reset button that holds all CPU
// resets, then releases them one channel at a time on that channel's enable.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int NUM_CH            = 2,
  parameter int DIV_W             = 16,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_button_n,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic [NUM_CH-1:0]       i_ch_en,
  output logic [NUM_CH-1:0]       o_ce,
  output logic [NUM_CH-1:0]       o_phi,
  output logic [NUM_CH-1:0]       o_rst,
  output logic                    o_all_ready
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_ce_div #(.DIV_W(DIV_W)) u_div (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (i_ch_en[c]),
      .i_div (i_div[c*DIV_W +: DIV_W]),
      .o_ce  (o_ce[c]),
      .o_phi (o_phi[c])
    );
  end

  logic            btn_meta, btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic            pressed;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= i_button_n;
      btn_sync <= btn_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 db_cnt <= '0;
    else if (btn_sync)         db_cnt <= '0;
    else if (db_cnt != DB_MAX) db_cnt <= db_cnt + 1'b1;
  end

  assign pressed = (db_cnt >= DB_MAX);

  seq_state_e        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [NUM_CH-1:0] rst_next;
  logic              ready_next;
  logic              sel_ce, sel_en;

  always_comb begin
    sel_ce = 1'b0;
    sel_en = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx == IDX_W'(c)) begin
        sel_ce = o_ce[c];
        sel_en = i_ch_en[c];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_ASSERT;
      hold_cnt    <= '0;
      idx         <= '0;
      o_rst       <= '1;
      o_all_ready <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      idx         <= idx_next;
      o_rst       <= rst_next;
      o_all_ready <= ready_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    idx_next   = idx;
    rst_next   = o_rst;
    ready_next = o_all_ready;

    if (pressed) begin
      state_next = S_ASSERT;
      hold_next  = '0;
      idx_next   = '0;
      rst_next   = '1;
      ready_next = 1'b0;
    end else begin
      unique case (state)
        S_ASSERT: begin
          rst_next   = '1;
          ready_next = 1'b0;
          if (btn_sync) begin
            state_next = S_HOLD;
            hold_next  = '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = S_RELEASE;
            idx_next   = '0;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          // a disabled channel never pulses, so it is released without waiting
          if (sel_ce || !sel_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (idx == IDX_W'(c)) rst_next[c] = 1'b0;
            end
            if (idx == IDX_LAST) begin
              state_next = S_RUN;
              ready_next = 1'b1;
            end else begin
              idx_next = idx + 1'b1;
            end
          end
        end
        S_RUN: begin
          rst_next   = '0;
          ready_next = 1'b1;
        end
        default: state_next = S_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench for clk_rst_seq: expectations are queued when stimulus is
// applied and compared when the matching DUT event is observed.
module tb_clk_rst_seq;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    button_n;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ce, phi, rst_out;
  logic                    all_ready;

  always #5 clk = ~clk;

  clk_rst_seq #(
    .NUM_CH            (NUM_CH),
    .DIV_W             (DIV_W),
    .DEBOUNCE_CYCLES   (8),
    .RESET_HOLD_CYCLES (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_button_n  (button_n),
    .i_div       (div),
    .i_ch_en     (ch_en),
    .o_ce        (ce),
    .o_phi       (phi),
    .o_rst       (rst_out),
    .o_all_ready (all_ready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    total = 0;
  int    bad   = 0;
  string tag_q[$];
  int    val_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic expect_val(input string tag, input int val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic score(input int got);
    if (val_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: got %0d, expected no further result", got);
    end else begin
      check(tag_q.pop_front(), got, val_q.pop_front());
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $display("FAIL %s: got timeout, expected event", tag);
  endtask

  task automatic wait_ce(input int c, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ce[c]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout("ce_wait");
  endtask

  task automatic wait_phi_change(input int c, input bit rise_only, output int at);
    logic prev;
    prev = phi[c];
    at   = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (phi[c] != prev && (!rise_only || phi[c])) begin
        at = cyc;
        break;
      end
      prev = phi[c];
    end
    if (at < 0) timeout("phi_wait");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int a, b, cnt_a, cnt_b, fa, f0, f1, fr, fce, rdy_at_fa;
    bit found;

    rst      = 1'b1;
    button_n = 1'b1;
    ch_en    = 2'b11;
    div      = {16'd9, 16'd4};
    repeat (3) @(negedge clk);

    // reset values
    expect_val("reset_o_rst", 3);  score(rst_out);
    expect_val("reset_ready", 0);  score(all_ready);
    expect_val("reset_ce", 0);     score(ce);
    expect_val("reset_phi", 0);    score(phi);

    // release sequence after reset: hold 1..4, ce0 at 5, ce1 at 10
    fce = -1; f0 = -1; f1 = -1; fr = -1;
    expect_val("first_ce0", 5);
    expect_val("rel_rst0_fall", 6);
    expect_val("rel_rst1_fall", 11);
    expect_val("rel_ready_rise", 11);
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (fce < 0 && ce[0]) fce = n;
      if (f0 < 0 && !rst_out[0]) f0 = n;
      if (f1 < 0 && !rst_out[1]) f1 = n;
      if (fr < 0 && all_ready) fr = n;
    end
    score(fce); score(f0); score(f1); score(fr);

    // divider periods and phase relation
    for (int k = 0; k < 3; k++) expect_val("ce0_period", 5);
    wait_ce(0, a);
    for (int k = 0; k < 3; k++) begin wait_ce(0, b); score(b - a); a = b; end
    for (int k = 0; k < 2; k++) expect_val("ce1_period", 10);
    wait_ce(1, a);
    for (int k = 0; k < 2; k++) begin wait_ce(1, b); score(b - a); a = b; end
    for (int k = 0; k < 2; k++) expect_val("phi0_period", 10);
    wait_phi_change(0, 1'b1, a);
    for (int k = 0; k < 2; k++) begin wait_phi_change(0, 1'b1, b); score(b - a); a = b; end
    for (int k = 0; k < 2; k++) expect_val("phi1_period", 20);
    wait_phi_change(1, 1'b1, a);
    for (int k = 0; k < 2; k++) begin wait_phi_change(1, 1'b1, b); score(b - a); a = b; end
    expect_val("phi0_lag", 1);
    wait_ce(0, a);
    wait_phi_change(0, 1'b0, b);
    score(b - a);

    // short press is ignored
    expect_val("short_press_rst", 0);
    expect_val("short_press_ready_drop", 0);
    cnt_a = 0; cnt_b = 0;
    button_n = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 5) button_n = 1'b1;
      if (rst_out != 0) cnt_a++;
      if (!all_ready) cnt_b++;
    end
    score(cnt_a); score(cnt_b);

    // long press aligned to ce1 (ce0 coincides): assert at 11, hold 24..27,
    // release ce0 at 30 -> 31, ce1 at 40 -> 41
    wait_ce(1, a);
    expect_val("ce0_aligned", 1);
    score(ce[0]);
    fa = -1; f0 = -1; f1 = -1; fr = -1; rdy_at_fa = -1;
    expect_val("press_assert_cycle", 11);
    expect_val("press_ready_low", 0);
    expect_val("press_rst0_fall", 31);
    expect_val("press_rst1_fall", 41);
    expect_val("press_ready_rise", 41);
    button_n = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (fa < 0 && rst_out == 2'b11) begin fa = n; rdy_at_fa = int'(all_ready); end
      if (fa >= 0 && f0 < 0 && !rst_out[0]) f0 = n;
      if (fa >= 0 && f1 < 0 && !rst_out[1]) f1 = n;
      if (fa >= 0 && fr < 0 && all_ready) fr = n;
      if (n == 20) button_n = 1'b1;
    end
    score(fa); score(rdy_at_fa); score(f0); score(f1); score(fr);

    // divisor lowered 9 -> 2 while ch1 count is 6
    wait_ce(1, a);
    repeat (6) @(negedge clk);
    div[31:16] = 16'd2;
    a = cyc;
    expect_val("div_drop_lag", 1);
    expect_val("div_drop_period", 3);
    expect_val("div_drop_period", 3);
    for (int k = 0; k < 3; k++) begin wait_ce(1, b); score(b - a); a = b; end

    // channel 1 disabled
    ch_en = 2'b01;
    repeat (2) @(negedge clk);
    expect_val("dis_activity", 0);
    cnt_a = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ce[1] || phi[1]) cnt_a++;
    end
    score(cnt_a);
    fa = -1; f0 = -1; f1 = -1; fr = -1;
    expect_val("dis_seq_seen", 1);
    expect_val("dis_rst1_gap", 1);
    expect_val("dis_ready_gap", 0);
    button_n = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (fa < 0 && rst_out == 2'b11) fa = n;
      if (fa >= 0 && f0 < 0 && !rst_out[0]) f0 = n;
      if (fa >= 0 && f1 < 0 && !rst_out[1]) f1 = n;
      if (fa >= 0 && fr < 0 && all_ready) fr = n;
      if (n == 12) button_n = 1'b1;
    end
    score(int'(fa > 0 && f0 > 0 && f1 > 0));
    score(f1 - f0);
    score(fr - f1);

    // reset asserted mid-release with o_rst = 2'b10
    ch_en      = 2'b11;
    div[31:16] = 16'd9;
    button_n   = 1'b0;
    repeat (12) @(negedge clk);
    button_n = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rst_out == 2'b10) begin found = 1'b1; break; end
    end
    expect_val("partial_release_seen", 1);
    score(found);
    rst = 1'b1;
    #1;
    expect_val("async_o_rst", 3);  score(rst_out);
    expect_val("async_ready", 0);  score(all_ready);
    expect_val("async_ce", 0);     score(ce);
    expect_val("async_phi", 0);    score(phi);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_val("post_rst_held", 3);
    score(rst_out);
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (all_ready) begin found = 1'b1; break; end
    end
    expect_val("post_rst_ready", 1);
    score(found);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
